pipe_hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage 32-bit core: IF, ID, EX, MEM, WB.
- Drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Generates EX-stage operand forwarding selects.
- Resolves load-use hazards, taken-branch flushes, data-memory wait states and debug halt/drain.
- Sits beside the decode stage and observes register indices and control bits from ID, EX, MEM and WB.

---
 rtl/pipe_ctrl_pkg.sv | 50 +++++
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states, forwarding selects and
// the bundle of register enable/flush controls driven into the datapath.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef logic [3:0] reg_idx_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_FREEZE = pipe_ctl_t'(7'b00000_00);
    localparam pipe_ctl_t CTL_FLOW   = pipe_ctl_t'(7'b11111_00);

    // The younger producer (MEM) wins over WB; index 0 gets no special treatment.
    function automatic fwd_sel_t fwd_select(
        input reg_idx_t src,
        input logic     mem_rwrite,
        input reg_idx_t mem_rd,
        input logic     wb_rwrite,
        input reg_idx_t wb_rd
    );
        if (mem_rwrite && (mem_rd == src)) begin
            return FWD_MEM;
        end
        if (wb_rwrite && (wb_rd == src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding selection for both ALU sources.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  reg_idx_t ex_rn,
    input  reg_idx_t ex_rm,
    input  reg_idx_t mem_rd,
    input  reg_idx_t wb_rd,
    input  logic     mem_rwrite,
    input  logic     wb_rwrite,
    output fwd_sel_t fwd_a,
    output fwd_sel_t fwd_b
);

    assign fwd_a = fwd_select(ex_rn, mem_rwrite, mem_rd, wb_rwrite, wb_rd);
    assign fwd_b = fwd_select(ex_rm, mem_rwrite, mem_rd, wb_rwrite, wb_rd);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stage enables/flushes, forwarding,
// load-use and branch hazards, data-memory wait states and debug halt/drain.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_rn,
    input  logic [3:0]       id_rm,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic [3:0]       ex_rn,
    input  logic [3:0]       ex_rm,
    input  logic [3:0]       ex_rd,
    input  logic             ex_rwrite,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic [3:0]       mem_rd,
    input  logic [3:0]       wb_rd,
    input  logic             mem_rwrite,
    input  logic             wb_rwrite,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [DRN_W-1:0]  DRN_LIM  = DRN_W'(DRAIN_CYCLES);
    localparam logic [DRN_W-1:0]  DRN_ONE  = DRN_W'(1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              init_q;

    logic      hold;
    logic      load_use;
    logic      mem_stall;
    pipe_ctl_t run_ctl;
    logic      run_to_drain;
    pipe_ctl_t fsm_ctl;
    pipe_ctl_t ctl;
    fwd_sel_t  fwd_a_raw, fwd_b_raw;

    // The reset cycle and the one right after it present a quiet pipeline.
    assign hold      = reset | init_q;
    assign load_use  = ex_is_load && ex_rwrite &&
                       ((id_rn_used && (id_rn == ex_rd)) ||
                        (id_rm_used && (id_rm == ex_rd)));
    assign mem_stall = mem_req && !mem_ack;

    fwd_unit u_fwd (
        .ex_rn      (ex_rn),
        .ex_rm      (ex_rm),
        .mem_rd     (mem_rd),
        .wb_rd      (wb_rd),
        .mem_rwrite (mem_rwrite),
        .wb_rwrite  (wb_rwrite),
        .fwd_a      (fwd_a_raw),
        .fwd_b      (fwd_b_raw)
    );

    // Normal-flow decision, shared by RUN and the ack cycle of MEM_WAIT.
    always_comb begin
        run_ctl      = CTL_FLOW;
        run_to_drain = 1'b0;
        if (ex_branch_taken) begin
            run_ctl.ifid_flush = 1'b1;
            run_ctl.idex_flush = 1'b1;
        end else if (load_use) begin
            run_ctl.pc_en      = 1'b0;
            run_ctl.ifid_en    = 1'b0;
            run_ctl.idex_flush = 1'b1;
        end else if (halt_req) begin
            run_ctl.pc_en      = 1'b0;
            run_ctl.ifid_flush = 1'b1;
            run_to_drain       = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        drain_d   = drain_q;
        mem_err_d = mem_err_q;
        fsm_ctl   = CTL_FREEZE;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d   = MEM_WAIT;
                    wait_d    = WAIT_ONE;
                    mem_err_d = mem_err_q | (WAIT_ONE >= WAIT_LIM);
                end else begin
                    fsm_ctl = run_ctl;
                    if (run_to_drain) begin
                        drain_d = DRN_ONE;
                        state_d = (DRN_ONE >= DRN_LIM) ? HALTED : DRAIN;
                    end
                end
            end
            MEM_WAIT: begin
                if (!mem_ack) begin
                    wait_d = (wait_q >= WAIT_LIM) ? wait_q : wait_q + WAIT_ONE;
                    if (wait_d >= WAIT_LIM) begin
                        mem_err_d = 1'b1;
                    end
                end else begin
                    fsm_ctl = run_ctl;
                    wait_d  = '0;
                    state_d = RUN;
                    if (run_to_drain) begin
                        drain_d = DRN_ONE;
                        state_d = (DRN_ONE >= DRN_LIM) ? HALTED : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!mem_stall) begin
                    fsm_ctl            = CTL_FLOW;
                    fsm_ctl.pc_en      = 1'b0;
                    fsm_ctl.ifid_flush = 1'b1;
                    fsm_ctl.idex_flush = ex_branch_taken;
                    drain_d            = drain_q + DRN_ONE;
                    if (drain_d >= DRN_LIM) begin
                        drain_d = '0;
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                if (!halt_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (init_q) begin
            state_d   = RUN;
            wait_d    = '0;
            drain_d   = '0;
            mem_err_d = 1'b0;
        end
    end

    assign ctl = hold ? CTL_FREEZE : fsm_ctl;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctl.pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_q      <= '0;
            drain_q     <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            init_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            drain_q     <= drain_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            init_q      <= 1'b0;
        end
    end

    assign pc_en      = ctl.pc_en;
    assign ifid_en    = ctl.ifid_en;
    assign idex_en    = ctl.idex_en;
    assign exmem_en   = ctl.exmem_en;
    assign memwb_en   = ctl.memwb_en;
    assign ifid_flush = ctl.ifid_flush;
    assign idex_flush = ctl.idex_flush;
    assign fwd_a      = hold ? FWD_RF : fwd_a_raw;
    assign fwd_b      = hold ? FWD_RF : fwd_b_raw;
    assign halted     = !hold && (state_q == HALTED);
    assign mem_err    = mem_err_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table for single-cycle
// decisions plus hand-written sequences for reset, halt/drain and memory waits.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [3:0] id_rn;
        logic [3:0] id_rm;
        logic       id_rn_used;
        logic       id_rm_used;
        logic [3:0] ex_rn;
        logic [3:0] ex_rm;
        logic [3:0] ex_rd;
        logic       ex_rwrite;
        logic       ex_is_load;
        logic       ex_branch_taken;
        logic [3:0] mem_rd;
        logic [3:0] wb_rd;
        logic       mem_rwrite;
        logic       wb_rwrite;
        logic       mem_req;
        logic       mem_ack;
    } vin_t;

    typedef struct {
        string      name;
        vin_t       vi;
        logic [4:0] en;
        logic       fi;
        logic       fd;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
    logic        id_rn_used, id_rm_used, ex_rwrite, ex_is_load, ex_branch_taken;
    logic        mem_rwrite, wb_rwrite, mem_req, mem_ack, halt_req;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, halted, mem_err;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_stall = 0;
    vec_t        vecs[$];

    pipe_hazard_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .id_rn           (id_rn),
        .id_rm           (id_rm),
        .id_rn_used      (id_rn_used),
        .id_rm_used      (id_rm_used),
        .ex_rn           (ex_rn),
        .ex_rm           (ex_rm),
        .ex_rd           (ex_rd),
        .ex_rwrite       (ex_rwrite),
        .ex_is_load      (ex_is_load),
        .ex_branch_taken (ex_branch_taken),
        .mem_rd          (mem_rd),
        .wb_rd           (wb_rd),
        .mem_rwrite      (mem_rwrite),
        .wb_rwrite       (wb_rwrite),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .halt_req        (halt_req),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .halted          (halted),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got 0x%0h expected 0x%0h", name, what, act, exp);
        end
    endtask

    task automatic apply_in(input vin_t v);
        id_rn           = v.id_rn;
        id_rm           = v.id_rm;
        id_rn_used      = v.id_rn_used;
        id_rm_used      = v.id_rm_used;
        ex_rn           = v.ex_rn;
        ex_rm           = v.ex_rm;
        ex_rd           = v.ex_rd;
        ex_rwrite       = v.ex_rwrite;
        ex_is_load      = v.ex_is_load;
        ex_branch_taken = v.ex_branch_taken;
        mem_rd          = v.mem_rd;
        wb_rd           = v.wb_rd;
        mem_rwrite      = v.mem_rwrite;
        wb_rwrite       = v.wb_rwrite;
        mem_req         = v.mem_req;
        mem_ack         = v.mem_ack;
    endtask

    // Checks one cycle at the falling edge, then advances past the rising edge
    // and updates the stall-count model from the expected pc_en.
    task automatic run_cycle(input string name, input logic [4:0] e_en,
                             input logic e_fi, input logic e_fd,
                             input logic [1:0] e_fa, input logic [1:0] e_fb,
                             input logic e_halted, input logic e_err);
        @(negedge clk);
        check(name, "ctl {en,fi,fd,fa,fb}",
              32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, fwd_a, fwd_b}),
              32'({e_en, e_fi, e_fd, e_fa, e_fb}));
        check(name, "halted", 32'(halted), 32'(e_halted));
        check(name, "mem_err", 32'(mem_err), 32'(e_err));
        check(name, "stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        @(posedge clk);
        #1;
        if (reset) exp_stall = 0;
        else if (!e_en[4] && exp_stall < 65535) exp_stall++;
    endtask

    task automatic add_vec(input string name, input vin_t v, input logic [4:0] en,
                           input logic fi, input logic fd,
                           input logic [1:0] fa, input logic [1:0] fb);
        vec_t t;
        t.name = name; t.vi = v; t.en = en; t.fi = fi; t.fd = fd; t.fa = fa; t.fb = fb;
        vecs.push_back(t);
    endtask

    initial begin
        vin_t v;

        // Vector table: every record leaves the FSM in RUN.
        v = '0;
        add_vec("idle", v, 5'b11111, 0, 0, 2'b00, 2'b00);
        v = '0; v.mem_rwrite = 1; v.mem_rd = 3; v.wb_rwrite = 1; v.wb_rd = 3;
        v.ex_rn = 3; v.ex_rm = 5;
        add_vec("fwd_mem_prio", v, 5'b11111, 0, 0, 2'b01, 2'b00);
        v.mem_rwrite = 0;
        add_vec("fwd_wb", v, 5'b11111, 0, 0, 2'b10, 2'b00);
        v.mem_rwrite = 1; v.mem_rd = 5;
        add_vec("fwd_split", v, 5'b11111, 0, 0, 2'b10, 2'b01);
        v = '0; v.mem_rwrite = 1; v.mem_rd = 0;
        add_vec("fwd_r0", v, 5'b11111, 0, 0, 2'b01, 2'b01);
        v = '0; v.wb_rwrite = 1; v.wb_rd = 9; v.ex_rn = 9; v.ex_rm = 9;
        add_vec("fwd_wb_both", v, 5'b11111, 0, 0, 2'b10, 2'b10);
        v = '0; v.mem_rd = 4; v.wb_rd = 4; v.ex_rn = 4; v.ex_rm = 4;
        add_vec("fwd_no_write", v, 5'b11111, 0, 0, 2'b00, 2'b00);
        v = '0; v.ex_is_load = 1; v.ex_rwrite = 1; v.ex_rd = 7; v.id_rm = 7;
        v.id_rm_used = 1; v.id_rn = 1; v.ex_rn = 8; v.ex_rm = 8;
        add_vec("lu_rm", v, 5'b00111, 0, 1, 2'b00, 2'b00);
        v.id_rm_used = 0;
        add_vec("lu_rm_unused", v, 5'b11111, 0, 0, 2'b00, 2'b00);
        v = '0; v.ex_is_load = 1; v.ex_rwrite = 1; v.ex_rd = 2; v.id_rn = 2;
        v.id_rn_used = 1; v.id_rm = 2; v.ex_rn = 8; v.ex_rm = 8;
        add_vec("lu_rn", v, 5'b00111, 0, 1, 2'b00, 2'b00);
        v.ex_rwrite = 0;
        add_vec("lu_no_rwrite", v, 5'b11111, 0, 0, 2'b00, 2'b00);
        v.ex_rwrite = 1; v.ex_is_load = 0;
        add_vec("lu_not_load", v, 5'b11111, 0, 0, 2'b00, 2'b00);
        v.ex_is_load = 1; v.ex_branch_taken = 1;
        add_vec("br_over_lu", v, 5'b11111, 1, 1, 2'b00, 2'b00);
        v = '0; v.ex_branch_taken = 1; v.ex_rn = 1; v.ex_rm = 1;
        add_vec("br_alone", v, 5'b11111, 1, 1, 2'b00, 2'b00);
        v = '0; v.mem_req = 1; v.mem_ack = 1; v.ex_rn = 1; v.ex_rm = 1;
        add_vec("mem_ack_same", v, 5'b11111, 0, 0, 2'b00, 2'b00);

        // Reset with matching forwarding inputs: everything must stay quiet.
        halt_req = 0;
        reset = 1;
        v = '0; v.mem_rwrite = 1; v.mem_rd = 3; v.ex_rn = 3; v.ex_rm = 3;
        apply_in(v);
        run_cycle("rst_a", 5'b00000, 0, 0, 2'b00, 2'b00, 0, 0);
        run_cycle("rst_b", 5'b00000, 0, 0, 2'b00, 2'b00, 0, 0);
        reset = 0;
        run_cycle("rst_first_after", 5'b00000, 0, 0, 2'b00, 2'b00, 0, 0);
        run_cycle("rst_release", 5'b11111, 0, 0, 2'b01, 2'b01, 0, 0);

        foreach (vecs[i]) begin
            apply_in(vecs[i].vi);
            run_cycle(vecs[i].name, vecs[i].en, vecs[i].fi, vecs[i].fd,
                      vecs[i].fa, vecs[i].fb, 0, 0);
        end
        apply_in('0);

        // Two-cycle halt pulse: four drain cycles, one halted cycle, then run.
        halt_req = 1;
        run_cycle("hp_d1", 5'b01111, 1, 0, 2'b00, 2'b00, 0, 0);
        run_cycle("hp_d2", 5'b01111, 1, 0, 2'b00, 2'b00, 0, 0);
        halt_req = 0;
        run_cycle("hp_d3", 5'b01111, 1, 0, 2'b00, 2'b00, 0, 0);
        run_cycle("hp_d4", 5'b01111, 1, 0, 2'b00, 2'b00, 0, 0);
        run_cycle("hp_halted", 5'b00000, 0, 0, 2'b00, 2'b00, 1, 0);
        run_cycle("hp_run", 5'b11111, 0, 0, 2'b00, 2'b00, 0, 0);

        // Halt held: remains halted until the request drops.
        halt_req = 1;
        for (int i = 0; i < 4; i++)
            run_cycle("hh_drain", 5'b01111, 1, 0, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++)
            run_cycle("hh_halted", 5'b00000, 0, 0, 2'b00, 2'b00, 1, 0);
        halt_req = 0;
        run_cycle("hh_release", 5'b00000, 0, 0, 2'b00, 2'b00, 1, 0);
        run_cycle("hh_run", 5'b11111, 0, 0, 2'b00, 2'b00, 0, 0);

        // Drain frozen by a memory stall, then a taken branch mid-drain.
        halt_req = 1;
        run_cycle("ds_d1", 5'b01111, 1, 0, 2'b00, 2'b00, 0, 0);
        halt_req = 0;
        mem_req = 1; mem_ack = 0;
        run_cycle("ds_frz1", 5'b00000, 0, 0, 2'b00, 2'b00, 0, 0);
        run_cycle("ds_frz2", 5'b00000, 0, 0, 2'b00, 2'b00, 0, 0);
        mem_req = 0;
        run_cycle("ds_d2", 5'b01111, 1, 0, 2'b00, 2'b00, 0, 0);
        ex_branch_taken = 1;
        run_cycle("ds_d3_br", 5'b01111, 1, 1, 2'b00, 2'b00, 0, 0);
        ex_branch_taken = 0;
        run_cycle("ds_d4", 5'b01111, 1, 0, 2'b00, 2'b00, 0, 0);
        run_cycle("ds_halted", 5'b00000, 0, 0, 2'b00, 2'b00, 1, 0);
        run_cycle("ds_run", 5'b11111, 0, 0, 2'b00, 2'b00, 0, 0);

        // 70-cycle memory wait: mem_err appears after the 64th waiting cycle.
        mem_req = 1; mem_ack = 0;
        for (int c = 1; c <= 70; c++)
            run_cycle($sformatf("mw_c%0d", c), 5'b00000, 0, 0, 2'b00, 2'b00, 0, c > 64);
        mem_ack = 1;
        run_cycle("mw_ack", 5'b11111, 0, 0, 2'b00, 2'b00, 0, 1);
        mem_req = 0; mem_ack = 0;
        run_cycle("mw_after", 5'b11111, 0, 0, 2'b00, 2'b00, 0, 1);
        run_cycle("mw_sticky", 5'b11111, 0, 0, 2'b00, 2'b00, 0, 1);

        // Reset while waiting on memory with mem_err set.
        mem_req = 1; mem_ack = 0;
        run_cycle("rw_w1", 5'b00000, 0, 0, 2'b00, 2'b00, 0, 1);
        run_cycle("rw_w2", 5'b00000, 0, 0, 2'b00, 2'b00, 0, 1);
        reset = 1;
        run_cycle("rw_rst", 5'b00000, 0, 0, 2'b00, 2'b00, 0, 1);
        reset = 0;
        run_cycle("rw_first_after", 5'b00000, 0, 0, 2'b00, 2'b00, 0, 0);
        mem_req = 0;
        run_cycle("rw_run", 5'b11111, 0, 0, 2'b00, 2'b00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout, got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
